// File: rtl/axi4_slave_write_resp_tracker_if.sv
// AXI4 write-channel subset (AW/W/B handshakes) seen by the write response tracker.
// wdata is not carried; the tracker only needs beat framing.
interface axi4_slave_write_resp_tracker_if #(
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned LEN_WIDTH = 4
);
    logic [ID_WIDTH-1:0]  awid;
    logic [LEN_WIDTH-1:0] awlen;
    logic                 awvalid;
    logic                 awready;
    logic                 wvalid;
    logic                 wready;
    logic                 wlast;
    logic [ID_WIDTH-1:0]  bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    modport master (
        output awid, awlen, awvalid, wvalid, wlast, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awlen, awvalid, wvalid, wlast, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi4_slave_write_resp_tracker.sv
// AXI4 slave write response tracker: queues accepted AWs, frames W bursts, issues in-order B responses.
// Optional AXI4_WLAST_CHECK_EN: terminate on wlast or beat count == awlen, SLVERR unless both coincide.
module axi4_slave_write_resp_tracker #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ID_WIDTH  = 4,
    parameter int unsigned LEN_WIDTH = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    axi4_slave_write_resp_tracker_if.slave bus,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_count,
    output logic                       aw_full
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ENT_W = ID_WIDTH + LEN_WIDTH;

    logic [ENT_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [LEN_WIDTH-1:0] beat;
    logic                 bvalid_q;
    logic [ID_WIDTH-1:0]  bid_q;
    logic [1:0]           bresp_q;

    logic                 push;
    logic                 w_hs;
    logic                 term;
    logic [1:0]           term_resp;
    logic [ID_WIDTH-1:0]  head_id;
    logic [LEN_WIDTH-1:0] head_len;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign aw_full           = (count == CNT_W'(DEPTH));
    assign outstanding_count = count;
    // Both readies come from registered state so a fresh AW cannot enable W in its own cycle.
    assign bus.awready = aresetn && !aw_full;
    assign bus.wready  = aresetn && (count != '0) && !bvalid_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;

    assign push = bus.awvalid && bus.awready;
    assign w_hs = bus.wvalid && bus.wready;
    assign {head_id, head_len} = mem[rd_ptr];

`ifdef AXI4_WLAST_CHECK_EN
    always_comb begin
        term      = w_hs && (bus.wlast || (beat == head_len));
        term_resp = (bus.wlast && (beat == head_len)) ? 2'b00 : 2'b10;
    end
`else
    logic unused_len;
    assign unused_len = ^{head_len};

    always_comb begin
        term      = w_hs && bus.wlast;
        term_resp = 2'b00;
    end
`endif

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.awid, bus.awlen};
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat     <= '0;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (term) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, term})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (term) begin
                beat <= '0;
            end else if (w_hs) begin
                beat <= beat + 1'b1;
            end

            // wready is low while bvalid is high, so set and clear never collide.
            if (term) begin
                bvalid_q <= 1'b1;
                bid_q    <= head_id;
                bresp_q  <= term_resp;
            end else if (bvalid_q && bus.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end
endmodule

// File: doc/axi4_slave_write_resp_tracker.md
AXI4_SLAVE_WRITE_RESP_TRACKER -- requirements
Module: axi4_slave_write_resp_tracker

Interface
REQ-001 Parameter DEPTH, default 16, is the maximum number of accepted write addresses awaiting a response (outstanding write depth).
REQ-002 Parameter ID_WIDTH, default 4, is the width of awid/bid.
REQ-003 Parameter LEN_WIDTH, default 4, is the width of awlen (beats minus one).
REQ-004 aclk  in  1  sole clock; all state updates on its rising edge.
REQ-005 aresetn  in  1  reset, synchronous, active-low.
REQ-006 awid  in  ID_WIDTH  write address ID.
REQ-007 awlen  in  LEN_WIDTH  burst length minus one.
REQ-008 awvalid / awready  in / out  1 each  write address handshake.
REQ-009 wvalid / wready  in / out  1 each  write data handshake; wdata is not routed through this block.
REQ-010 wlast  in  1  last beat of the current burst.
REQ-011 bid  out  ID_WIDTH  response ID.
REQ-012 bresp  out  2  response code: 2'b00 OKAY, 2'b10 SLVERR.
REQ-013 bvalid / bready  out / in  1 each  write response handshake.
REQ-014 outstanding_count  out  $clog2(DEPTH+1)  current AW FIFO occupancy.
REQ-015 aw_full  out  1  high when occupancy == DEPTH.

Function
REQ-016 An internal FIFO of DEPTH entries shall store {awid, awlen}; an entry is pushed on every cycle with awvalid && awready.
REQ-017 awready shall be !aw_full; a push and a pop in the same cycle leave occupancy unchanged.
REQ-018 wready shall be high only when the FIFO is non-empty and bvalid is low.
REQ-019 A 0..2^LEN_WIDTH-1 beat counter shall increment on each W handshake and clear when the burst terminates.
REQ-020 A burst shall terminate on the W handshake that ends it (see REQ-030/031); that cycle pops the FIFO head and clears the beat counter.
REQ-021 On the cycle after termination, bvalid shall be 1, bid shall be the popped awid, and bresp shall be the computed code.
REQ-022 bvalid, bid and bresp shall remain stable until a cycle with bvalid && bready; bvalid falls on the following edge.
REQ-023 An AW accepted into an empty FIFO shall not allow W acceptance until the next cycle (wready derives from registered occupancy).
REQ-024 Responses shall be issued strictly in AW acceptance order.
REQ-025 FIFO pointers shall wrap modulo DEPTH; DEPTH need not be a power of two.
REQ-026 awvalid while aw_full shall cause no push and no state change; W beats while the FIFO is empty shall not be accepted.

Reset
REQ-027 While aresetn is low at a clock edge: FIFO pointers, occupancy, beat counter, bvalid, bid and bresp shall be cleared to 0.
REQ-028 awready and wready shall be forced to 0 while aresetn is low; awready shall be 1 on the first cycle after release.
REQ-029 Reset mid-burst or with bvalid high shall discard all outstanding entries and the pending response, with no response issued.

Configuration
REQ-030 With AXI4_WLAST_CHECK_EN defined: a burst terminates on the first beat where wlast == 1 or beat count == awlen; bresp = 2'b00 only if both occur together, otherwise 2'b10.
REQ-031 Without AXI4_WLAST_CHECK_EN: a burst terminates only on a W handshake with wlast == 1, the beat count is ignored, and bresp is always 2'b00.

Verification
REQ-032 Single AW id=3 len=3; four W beats with wlast on 4th; bready=1 -> bvalid one cycle after 4th beat, bid=3, bresp=00, count 1->0.
REQ-033 Push 16 AWs with W held off -> aw_full=1, awready=0, count=16; a 17th awvalid is ignored; one completed burst restores awready=1.
REQ-034 AW ids 1,2,5 with len 0,1,0; data streamed back-to-back; bready low 3 cycles per response -> bids 1,2,5 in order, wready low while bvalid high.
REQ-035 With AXI4_WLAST_CHECK_EN: len=3, wlast on beat 2 -> bresp=10 after beat 2; next AW's burst is unaffected. Without the macro: the same stimulus gives bresp=00.
REQ-036 aresetn low for one cycle with 2 outstanding AWs and bvalid=1 -> next cycle bvalid=0 and count=0; awready=1 after release; no stale response appears.
REQ-037 Push while the last W of the head burst completes, with occupancy at DEPTH-1 -> occupancy is unchanged and pointers wrap correctly across 3 full FIFO cycles.
